// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// branch-operand stalls, taken-branch/jump flushes, data-memory freezes, perf counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsID,
    input  logic [4:0]       rtID,
    input  logic             UsesRtID,
    input  logic             BranchID,
    input  logic             BranchTakenID,
    input  logic             JumpID,
    input  logic             RegWriteEX,
    input  logic             MemReadEX,
    input  logic [4:0]       WriteRegEX,
    input  logic             MemReadMEM,
    input  logic [4:0]       WriteRegMEM,
    input  logic             DMemBusy,
    output logic             PCWrite,
    output logic             IFIDHold,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             PipeFreeze,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {RUN, STALL, FREEZE} state_e;

    state_e           state_q, state_d;
    state_e           ret_state_q, ret_state_d;
    state_e           eff_state;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             match_ex, match_mem;
    logic [1:0]       need;
    logic             hazard_stall;

    assign match_ex  = (WriteRegEX != 5'd0) &&
                       ((WriteRegEX == rsID) || (UsesRtID && (WriteRegEX == rtID)));
    assign match_mem = (WriteRegMEM != 5'd0) &&
                       ((WriteRegMEM == rsID) || (UsesRtID && (WriteRegMEM == rtID)));

    always_comb begin
        need = 2'd0;
        if (BranchID && MemReadEX && match_ex)
            need = 2'd2;
        else if ((MemReadEX && match_ex) || (BranchID && RegWriteEX && match_ex) ||
                 (BranchID && MemReadMEM && match_mem))
            need = 2'd1;
    end

    // A freeze resumes whichever state it interrupted, within the same cycle.
    assign eff_state = (state_q == FREEZE) ? ret_state_q : state_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        cnt_d        = cnt_q;
        PCWrite      = 1'b0;
        IFIDHold     = 1'b0;
        IFIDFlush    = 1'b0;
        IDEXFlush    = 1'b0;
        PipeFreeze   = 1'b0;
        hazard_stall = 1'b0;

        if (reset) begin
            state_d = RUN;
        end else if (DMemBusy) begin
            PipeFreeze  = 1'b1;
            IFIDHold    = 1'b1;
            state_d     = FREEZE;
            ret_state_d = eff_state;
        end else begin
            case (eff_state)
                STALL: begin
                    hazard_stall = 1'b1;
                    cnt_d        = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
                    state_d      = (cnt_q <= 2'd1) ? RUN : STALL;
                end
                default: begin
                    state_d = RUN;
                    if (need != 2'd0) begin
                        hazard_stall = 1'b1;
                        if (need == 2'd2) begin
                            cnt_d   = 2'd1;
                            state_d = STALL;
                        end
                    end else begin
                        PCWrite   = 1'b1;
                        IFIDFlush = JumpID || (BranchID && BranchTakenID);
                    end
                end
            endcase
            if (hazard_stall) begin
                IFIDHold  = 1'b1;
                IDEXFlush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (hazard_stall && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (IFIDFlush && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + 1'b1;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            ret_state_q    <= RUN;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            ret_state_q    <= ret_state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked against a
// model that tracks remaining stall cycles and saturating event counts.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rsID, rtID, WriteRegEX, WriteRegMEM;
    logic             UsesRtID, BranchID, BranchTakenID, JumpID;
    logic             RegWriteEX, MemReadEX, MemReadMEM, DMemBusy;
    logic             PCWrite, IFIDHold, IFIDFlush, IDEXFlush, PipeFreeze;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    int total = 0;
    int bad   = 0;

    // Reference model state: pending extra stall cycles and expected counter values.
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;
    int snap;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rsID(rsID), .rtID(rtID), .UsesRtID(UsesRtID),
        .BranchID(BranchID), .BranchTakenID(BranchTakenID), .JumpID(JumpID),
        .RegWriteEX(RegWriteEX), .MemReadEX(MemReadEX), .WriteRegEX(WriteRegEX),
        .MemReadMEM(MemReadMEM), .WriteRegMEM(WriteRegMEM), .DMemBusy(DMemBusy),
        .PCWrite(PCWrite), .IFIDHold(IFIDHold), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .PipeFreeze(PipeFreeze),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] r);
        return (r != 5'd0) && (r == rsID || (UsesRtID && r == rtID));
    endfunction

    function automatic int stall_need();
        if (BranchID && MemReadEX && dep(WriteRegEX)) return 2;
        if (MemReadEX && dep(WriteRegEX)) return 1;
        if (BranchID && RegWriteEX && dep(WriteRegEX)) return 1;
        if (BranchID && MemReadMEM && dep(WriteRegMEM)) return 1;
        return 0;
    endfunction

    task automatic clear();
        rsID = 0; rtID = 0; WriteRegEX = 0; WriteRegMEM = 0;
        UsesRtID = 0; BranchID = 0; BranchTakenID = 0; JumpID = 0;
        RegWriteEX = 0; MemReadEX = 0; MemReadMEM = 0; DMemBusy = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag);
        logic e_pc, e_hold, e_iff, e_exf, e_frz;
        int   n, next_left;
        e_pc = 0; e_hold = 0; e_iff = 0; e_exf = 0; e_frz = 0;
        next_left = m_left;
        #1;
        if (reset) begin
            next_left = 0;
        end else if (DMemBusy) begin
            e_frz = 1; e_hold = 1;
        end else if (m_left > 0) begin
            e_hold = 1; e_exf = 1;
            next_left = m_left - 1;
        end else begin
            n = stall_need();
            if (n > 0) begin
                e_hold = 1; e_exf = 1;
                next_left = n - 1;
            end else begin
                e_pc  = 1;
                e_iff = JumpID || (BranchID && BranchTakenID);
            end
        end
        chk({tag, ".PCWrite"},    16'(PCWrite),    16'(e_pc));
        chk({tag, ".IFIDHold"},   16'(IFIDHold),   16'(e_hold));
        chk({tag, ".IFIDFlush"},  16'(IFIDFlush),  16'(e_iff));
        chk({tag, ".IDEXFlush"},  16'(IDEXFlush),  16'(e_exf));
        chk({tag, ".PipeFreeze"}, 16'(PipeFreeze), 16'(e_frz));
        @(posedge clk);
        m_left = next_left;
        if (reset) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (e_exf && m_stall < SAT) m_stall++;
            if (e_iff && m_flush < SAT) m_flush++;
        end
        #1;
        chk({tag, ".StallCycles"}, 16'(StallCycles), 16'(m_stall));
        chk({tag, ".FlushCount"},  16'(FlushCount),  16'(m_flush));
        @(negedge clk);
    endtask

    initial begin
        clear();
        reset = 1;
        @(negedge clk);
        step("reset");
        reset = 0;
        step("idle");

        // Load-use on rs, then the same with $zero as destination.
        MemReadEX = 1; WriteRegEX = 8; rsID = 8;
        step("load_use");
        clear();
        step("load_use_after");
        chk("load_use_count", 16'(StallCycles), 16'd1);
        MemReadEX = 1; WriteRegEX = 0; rsID = 0;
        step("load_r0");

        // Load followed by beq on rt: two stall cycles, then resolved taken branch.
        clear();
        BranchID = 1; MemReadEX = 1; WriteRegEX = 9; rtID = 9; UsesRtID = 1;
        step("ld_br_1");
        step("ld_br_2");
        MemReadEX = 0; BranchTakenID = 1;
        step("ld_br_resolve");
        chk("ld_br_flushes", 16'(FlushCount), 16'd1);
        chk("ld_br_stalls",  16'(StallCycles), 16'd3);

        clear();
        BranchID = 1; BranchTakenID = 1;
        step("br_taken");
        clear();
        JumpID = 1;
        step("jump");

        // Data memory busy for three cycles inside the second branch stall cycle.
        clear();
        snap = int'(StallCycles);
        BranchID = 1; MemReadEX = 1; WriteRegEX = 9; rsID = 9;
        step("frz_stall_1");
        clear();
        DMemBusy = 1;
        for (int i = 0; i < 3; i++) step("frz_busy");
        DMemBusy = 0;
        step("frz_stall_2");
        step("frz_run");
        chk("frz_stall_delta", 16'(int'(StallCycles) - snap), 16'd2);

        // Twenty back-to-back jumps saturate the flush counter.
        clear();
        JumpID = 1;
        for (int i = 0; i < 20; i++) step("sat_jump");
        chk("flush_saturated", 16'(FlushCount), 16'd15);

        // Reset pulse while a load-to-branch stall is in progress.
        clear();
        BranchID = 1; MemReadEX = 1; WriteRegEX = 5; rsID = 5;
        step("rst_mid_1");
        reset = 1;
        step("rst_mid_hold");
        reset = 0;
        clear();
        step("rst_mid_run");

        // Random traffic with small register ids so dependencies are frequent.
        for (int i = 0; i < 400; i++) begin
            rsID          = 5'($urandom_range(0, 3));
            rtID          = 5'($urandom_range(0, 3));
            WriteRegEX    = 5'($urandom_range(0, 3));
            WriteRegMEM   = 5'($urandom_range(0, 3));
            UsesRtID      = 1'($urandom_range(0, 1));
            BranchID      = ($urandom_range(0, 99) < 40);
            BranchTakenID = 1'($urandom_range(0, 1));
            JumpID        = ($urandom_range(0, 99) < 15);
            RegWriteEX    = 1'($urandom_range(0, 1));
            MemReadEX     = ($urandom_range(0, 99) < 35);
            MemReadMEM    = ($urandom_range(0, 99) < 35);
            DMemBusy      = ($urandom_range(0, 99) < 15);
            reset         = ($urandom_range(0, 99) < 2);
            step("rand");
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
